uart_sim_rx_monitor: RTL

//  Simulation-side UART receiver that sits directly downstream of the SoC top level.
//  It consumes the serial TX line of the simulated SoC UART (the UART_SIM=1 build).
//  It oversamples the line 16x, deframes 8N1 characters and buffers them in a FWFT FIFO.

---
 rtl/uart_sim_rx_monitor.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/uart_sim_rx_monitor.sv
// 16x-oversampling 8N1 receiver for the simulated SoC UART TX line, buffered in a FWFT FIFO.
// Optional console echo of received bytes when UART_SIM_RX_DISPLAY_EN is defined.
module uart_sim_rx_monitor #(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned BAUD    = 115200,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic               rx_i,
  output logic [7:0]         data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               frame_err_o,
  output logic               overrun_o,
  output logic [FIFO_AW:0]   level_o
);

  localparam int unsigned DIV   = CLK_HZ / (BAUD * 16);
  localparam int unsigned TW    = $clog2(DIV);
  localparam int unsigned PW    = FIFO_AW + 1;
  localparam int unsigned DEPTH = 2 ** FIFO_AW;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Input synchroniser; idle-high reset value avoids a false start edge
  logic [1:0] sync_q;
  logic       rxs;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) sync_q <= 2'b11;
    else             sync_q <= {sync_q[0], rx_i};
  end

  assign rxs = sync_q[1];

  // Oversampling tick generator and receive FSM state
  state_t        state_q, state_n;
  logic [TW-1:0] tcnt_q, tcnt_n;
  logic [3:0]    sc_q, sc_n;
  logic [2:0]    bi_q, bi_n;
  logic [7:0]    shift_q, shift_n;
  logic          tick_c, tick_clr_c, push_c, ferr_c;
  logic          push_q;
  logic [7:0]    byte_q;

  assign tick_c = (tcnt_q == TW'(DIV - 1));
  assign tcnt_n = (tick_clr_c || tick_c) ? '0 : tcnt_q + TW'(1);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= S_IDLE;
      tcnt_q      <= '0;
      sc_q        <= '0;
      bi_q        <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      byte_q      <= '0;
      frame_err_o <= 1'b0;
    end else begin
      state_q     <= state_n;
      tcnt_q      <= tcnt_n;
      sc_q        <= sc_n;
      bi_q        <= bi_n;
      shift_q     <= shift_n;
      push_q      <= push_c;
      byte_q      <= shift_q;
      frame_err_o <= ferr_c;
    end
  end

  // Next state: start is confirmed at its mid-bit, data and stop sampled every 16 ticks after
  always_comb begin
    state_n    = state_q;
    sc_n       = sc_q;
    bi_n       = bi_q;
    shift_n    = shift_q;
    tick_clr_c = 1'b0;
    push_c     = 1'b0;
    ferr_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_n    = S_START;
          sc_n       = '0;
          tick_clr_c = 1'b1;
        end
      end
      S_START: begin
        if (tick_c) begin
          if (sc_q == 4'd7) begin
            if (!rxs) begin
              state_n = S_DATA;
              sc_n    = '0;
              bi_n    = '0;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            sc_n = sc_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick_c) begin
          sc_n = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            shift_n[bi_q] = rxs;
            bi_n          = bi_q + 3'd1;
            if (bi_q == 3'd7) state_n = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick_c) begin
          sc_n = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            push_c  = rxs;
            ferr_c  = ~rxs;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // FIFO with registered head; pointers carry an extra wrap bit
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_q, rd_q, wr_n, rd_n;
  logic          pop_c, full_c, wr_en_c, ovr_c;
  logic [7:0]    head_n;

  assign pop_c   = valid_o & ready_i;
  assign full_c  = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) &&
                   (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
  assign wr_en_c = push_q & (~full_c | pop_c);
  assign ovr_c   = push_q & full_c & ~pop_c;
  assign wr_n    = wr_q + PW'(wr_en_c);
  assign rd_n    = rd_q + PW'(pop_c);
  // The byte being written this cycle becomes the head when nothing older remains
  assign head_n  = (wr_en_c && (rd_n == wr_q)) ? byte_q : mem[rd_n[FIFO_AW-1:0]];

  always_ff @(posedge wb_clk_i) begin
    if (wr_en_c) mem[wr_q[FIFO_AW-1:0]] <= byte_q;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wr_q      <= '0;
      rd_q      <= '0;
      level_o   <= '0;
      valid_o   <= 1'b0;
      data_o    <= '0;
      overrun_o <= 1'b0;
    end else begin
      wr_q      <= wr_n;
      rd_q      <= rd_n;
      level_o   <= wr_n - rd_n;
      valid_o   <= (wr_n != rd_n);
      overrun_o <= ovr_c;
      if (wr_n != rd_n) data_o <= head_n;
    end
  end

`ifdef UART_SIM_RX_DISPLAY_EN
  // Console echo of the received stream
  always @(posedge wb_clk_i) begin
    if (wb_rst_n_i) begin
      if (wr_en_c && (byte_q != 8'h0D)) $write("%c", byte_q);
      if (ovr_c) $write("[OVR]");
      if (frame_err_o) $write("[FERR]");
    end
  end
`else
  // No console echo: block stays purely synthesisable
`endif

endmodule
